// File: rtl/phys_reg_ready_table_pkg.sv
// Shared defaults for the physical-register ready table: register count,
// lookup/writeback port counts and the physical address type.
package phys_reg_ready_table_pkg;

    localparam int PHYS_REGS_DEFAULT  = 64;
    localparam int READ_PORTS_DEFAULT = 2;
    localparam int WB_PORTS_DEFAULT   = 3;
    localparam int PHYS_ADDR_W        = $clog2(PHYS_REGS_DEFAULT);

    typedef logic [PHYS_ADDR_W-1:0] phys_addr_t;

endpackage

// File: rtl/phys_reg_ready_table.sv
// Per-physical-register "write outstanding" table sitting just after rename.
// A rename sets the pending bit of the new destination; writeback, issue
// rollback and discarded retire clear it. Source operands in issue look up
// readiness combinationally. Physical register 0 is never tracked.
//
// Optional feature: define PHYS_READY_WB_BYPASS_EN to let a same-cycle
// writeback (not rollback/discard) wake up a matching lookup immediately.
module phys_reg_ready_table
    import phys_reg_ready_table_pkg::*;
#(
    parameter int PHYS_REGS  = PHYS_REGS_DEFAULT,
    parameter int READ_PORTS = READ_PORTS_DEFAULT,
    parameter int WB_PORTS   = WB_PORTS_DEFAULT,
    localparam int AW = $clog2(PHYS_REGS),
    localparam int CW = AW + 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rename_valid,
    input  logic [AW-1:0]            rename_phys_addr,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*AW-1:0]   wb_phys_addr,
    input  logic                     rollback_valid,
    input  logic [AW-1:0]            rollback_phys_addr,
    input  logic                     discard_valid,
    input  logic [AW-1:0]            discard_phys_addr,
    input  logic [READ_PORTS*AW-1:0] rs_phys_addr,
    output logic [READ_PORTS-1:0]    rs_ready,
    output logic [CW-1:0]            pending_count
);

    logic [PHYS_REGS-1:0] pending;
    logic [PHYS_REGS-1:0] pending_next;
    logic [PHYS_REGS-1:0] set_mask;
    logic [PHYS_REGS-1:0] clear_mask;
    logic [PHYS_REGS-1:0] cleared;
    logic                 set_effective;
    logic [CW-1:0]        cleared_cnt;
    logic [CW-1:0]        pending_count_next;

    // One-hot decode of the set source and OR of all clear sources
    always_comb begin
        set_mask   = '0;
        clear_mask = '0;
        if (rename_valid && rename_phys_addr != '0)
            set_mask[rename_phys_addr] = 1'b1;
        for (int i = 0; i < WB_PORTS; i++) begin
            if (wb_valid[i])
                clear_mask[wb_phys_addr[i*AW +: AW]] = 1'b1;
        end
        if (rollback_valid)
            clear_mask[rollback_phys_addr] = 1'b1;
        if (discard_valid)
            clear_mask[discard_phys_addr] = 1'b1;
    end

    // Next table state and count delta; set wins over clear on the same bit,
    // and only bits that actually flip 1->0 are subtracted from the count
    always_comb begin
        pending_next  = (pending & ~clear_mask) | set_mask;
        cleared       = pending & clear_mask & ~set_mask;
        set_effective = |(set_mask & ~pending);
        cleared_cnt   = '0;
        for (int k = 0; k < PHYS_REGS; k++)
            cleared_cnt = cleared_cnt + CW'(cleared[k]);
        pending_count_next = pending_count + CW'(set_effective) - cleared_cnt;
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending       <= '0;
            pending_count <= '0;
        end else begin
            pending       <= pending_next;
            pending_count <= pending_count_next;
        end
    end

    // Readiness lookups; address 0 is always ready
    always_comb begin
        rs_ready = '0;
        for (int j = 0; j < READ_PORTS; j++) begin
            rs_ready[j] = (rs_phys_addr[j*AW +: AW] == '0) ||
                          !pending[rs_phys_addr[j*AW +: AW]];
`ifdef PHYS_READY_WB_BYPASS_EN
            for (int i = 0; i < WB_PORTS; i++) begin
                if (wb_valid[i] && wb_phys_addr[i*AW +: AW] == rs_phys_addr[j*AW +: AW])
                    rs_ready[j] = 1'b1;
            end
`endif
        end
    end

    // A set and a clear of the same register in one cycle never happens in the pipeline
    a_no_set_clear_collision: assert property (@(posedge clk) disable iff (!rst)
        (set_mask & clear_mask) == '0)
        else $error("phys_reg_ready_table: set and clear of same register");

    // Register 0 is never set, so at most PHYS_REGS-1 bits can be pending
    a_count_range: assert property (@(posedge clk) disable iff (!rst)
        pending_count <= CW'(PHYS_REGS - 1))
        else $error("phys_reg_ready_table: pending_count out of range");

endmodule

// File: tb/tb_phys_reg_ready_table.sv
// Scoreboard bench for phys_reg_ready_table: the driver pushes expected
// lookups/count computed from an array model; a monitor compares them.
module tb_phys_reg_ready_table;

    localparam int NREG = 64;
    localparam int AW   = 6;
`ifdef PHYS_READY_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rename_valid = 1'b0;
    logic [5:0]  rename_phys_addr = '0;
    logic [2:0]  wb_valid = '0;
    logic [17:0] wb_phys_addr = '0;
    logic        rollback_valid = 1'b0;
    logic [5:0]  rollback_phys_addr = '0;
    logic        discard_valid = 1'b0;
    logic [5:0]  discard_phys_addr = '0;
    logic [11:0] rs_phys_addr = '0;
    logic [1:0]  rs_ready;
    logic [6:0]  pending_count;

    phys_reg_ready_table dut (
        .clk                (clk),
        .rst                (rst),
        .rename_valid       (rename_valid),
        .rename_phys_addr   (rename_phys_addr),
        .wb_valid           (wb_valid),
        .wb_phys_addr       (wb_phys_addr),
        .rollback_valid     (rollback_valid),
        .rollback_phys_addr (rollback_phys_addr),
        .discard_valid      (discard_valid),
        .discard_phys_addr  (discard_phys_addr),
        .rs_phys_addr       (rs_phys_addr),
        .rs_ready           (rs_ready),
        .pending_count      (pending_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    a0;
        int    a1;
        bit    e0;
        bit    e1;
        int    cnt;
        string nm;
    } exp_t;

    exp_t exp_q[$];
    bit   pend[NREG];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < NREG; k++) c += int'(pend[k]);
        return c;
    endfunction

    task automatic check_val(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    // Monitor: compare whatever the driver has announced for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val($sformatf("%s rs_ready[0] addr %0d", e.nm, e.a0), int'(rs_ready[0]), int'(e.e0));
                check_val($sformatf("%s rs_ready[1] addr %0d", e.nm, e.a1), int'(rs_ready[1]), int'(e.e1));
                check_val($sformatf("%s pending_count", e.nm), int'(pending_count), e.cnt);
            end
        end
    end

    // Drive one cycle of inputs, announce expectation, advance the model
    task automatic apply(input bit rv, input int ra, input bit [2:0] wv,
                         input int w0, input int w1, input int w2,
                         input bit rbv, input int rba, input bit dv, input int da,
                         input int r0, input int r1, input string nm);
        int   wa[3];
        int   ra_l[2];
        bit   er[2];
        exp_t e;
        @(posedge clk);
        #1;
        wa[0] = w0; wa[1] = w1; wa[2] = w2;
        ra_l[0] = r0; ra_l[1] = r1;
        rename_valid       = rv;
        rename_phys_addr   = 6'(ra);
        wb_valid           = wv;
        wb_phys_addr       = {6'(w2), 6'(w1), 6'(w0)};
        rollback_valid     = rbv;
        rollback_phys_addr = 6'(rba);
        discard_valid      = dv;
        discard_phys_addr  = 6'(da);
        rs_phys_addr       = {6'(r1), 6'(r0)};
        for (int j = 0; j < 2; j++) begin
            er[j] = (ra_l[j] == 0) || !pend[ra_l[j]];
            if (BYP)
                for (int i = 0; i < 3; i++)
                    if (wv[i] && wa[i] == ra_l[j]) er[j] = 1'b1;
        end
        e.a0 = r0; e.a1 = r1; e.e0 = er[0]; e.e1 = er[1];
        e.cnt = model_count(); e.nm = nm;
        exp_q.push_back(e);
        for (int i = 0; i < 3; i++) if (wv[i]) pend[wa[i]] = 1'b0;
        if (rbv) pend[rba] = 1'b0;
        if (dv) pend[da] = 1'b0;
        if (rv && ra != 0) pend[ra] = 1'b1;
    endtask

    task automatic idle(input int r0, input int r1, input string nm);
        apply(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, r0, r1, nm);
    endtask

    task automatic rename(input int a, input string nm);
        apply(1, a, 3'b000, 0, 0, 0, 0, 0, 0, 0, a, 0, nm);
    endtask

    // Assert reset mid-cycle: everything must read ready right away
    task automatic do_reset(input int r0, input int r1, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rename_valid = 1'b0; wb_valid = '0; rollback_valid = 1'b0; discard_valid = 1'b0;
        rs_phys_addr = {6'(r1), 6'(r0)};
        for (int k = 0; k < NREG; k++) pend[k] = 1'b0;
        e.a0 = r0; e.a1 = r1; e.e0 = 1'b1; e.e1 = 1'b1; e.cnt = 0; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic release_reset(input int r0, input int r1, input string nm);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back('{r0, r1, 1'b1, 1'b1, 0, nm});
    endtask

    function automatic int pick();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 63));
        return int'($urandom_range(28, 45));
    endfunction

    initial begin
        for (int k = 0; k < NREG; k++) pend[k] = 1'b0;

        do_reset(0, 63, "reset");
        release_reset(5, 40, "reset_release");
        idle(0, 63, "reset_state");

        rename(33, "rename33");
        idle(33, 0, "rename33_n1");
        idle(33, 1, "rename33_n2");
        apply(0, 0, 3'b010, 0, 33, 0, 0, 0, 0, 0, 33, 32, "wb33_same");
        idle(33, 0, "wb33_next");

        apply(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rename0");
        idle(0, 1, "rename0_next");

        rename(34, "rename34");
        rename(35, "rename35");
        apply(0, 0, 3'b000, 0, 0, 0, 1, 34, 1, 35, 34, 35, "rb_ds_same");
        idle(34, 35, "rb_ds_next");

        rename(50, "rename50");
        apply(0, 0, 3'b111, 50, 50, 51, 0, 0, 0, 0, 50, 51, "dup_clear_same");
        idle(50, 51, "dup_clear_next");

        rename(5, "rename5");
        rename(40, "rename40");
        idle(5, 40, "pre_reset");
        do_reset(5, 40, "mid_reset");
        release_reset(5, 40, "mid_release");
        idle(5, 40, "post_reset");

        for (int a = 1; a < NREG; a++) rename(a, "fill");
        for (int k = 0; k < 32; k++) idle(2*k + 1, (2*k + 2) % NREG, "fill_check");
        for (int a = 1; a < NREG; a++)
            apply(0, 0, 3'b001, a, 0, 0, 0, 0, 0, 0, a, 0, "drain");
        idle(1, 63, "drained");

        for (int n = 0; n < 2000; n++) begin
            bit       rv, rbv, dv;
            bit [2:0] wv;
            int       ra, rba, da, r0, r1;
            int       wa[3];
            rv = $urandom_range(0, 1) == 1;
            ra = pick();
            for (int i = 0; i < 3; i++) begin
                wv[i] = $urandom_range(0, 9) < 3;
                wa[i] = pick();
            end
            rbv = $urandom_range(0, 9) < 2; rba = pick();
            dv  = $urandom_range(0, 9) < 2; da  = pick();
            r0 = pick(); r1 = pick();
            for (int i = 0; i < 3; i++) if (wv[i] && wa[i] == ra) rv = 1'b0;
            if ((rbv && rba == ra) || (dv && da == ra)) rv = 1'b0;
            apply(rv, ra, wv, wa[0], wa[1], wa[2], rbv, rba, dv, da, r0, r1, "random");
        end
        idle(0, 0, "final");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: left %0d expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
